// File: rtl/s2p_pkg.sv
// s2p_pkg: shared types and constants for the serial2parallel deserializer.
package s2p_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int ERR_CNT_W     = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/s2p_hold_reg.sv
// s2p_hold_reg: one-entry valid/ready holding register for reassembled words.
// A completed word is taken when the register is empty or draining this cycle;
// otherwise the word is dropped and ovf pulses for one cycle.
import s2p_pkg::*;

module s2p_hold_reg #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             ready_in,
  output logic [WIDTH-1:0] dout,
  output logic             valid_out,
  output logic             ovf
);

  logic accept;

  assign accept = !valid_out || ready_in;

  // Load, drop-with-overflow, or drain the held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout      <= '0;
      valid_out <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (load) begin
        if (accept) begin
          dout      <= word;
          valid_out <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (valid_out && ready_in) begin
        dout      <= '0;
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial2parallel.sv
// serial2parallel: rebuilds WIDTH-bit words from an MSB-first serial stream
// with a word-start strobe. Early strobes abort the partial frame (frame_err).
// Optional feature macro: SERIAL2PARALLEL_ERR_CNT_EN adds a saturating
// 8-bit error counter output err_cnt.
import s2p_pkg::*;

module serial2parallel #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             valid_in,
  output logic [WIDTH-1:0] dout,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             frame_err,
  output logic             ovf
`ifdef SERIAL2PARALLEL_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-2:0] sh;
  logic [WIDTH-1:0] shifted;
  logic             word_done;

  // The shifter only stores WIDTH-1 bits; the final bit comes straight from din.
  assign shifted   = {sh, din};
  assign word_done = (state == S_SHIFT) && !valid_in && (cnt == LAST);

  // Frame FSM and shifter: strobes start frames, early strobes restart them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sh        <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            sh    <= shifted[WIDTH-2:0];
            cnt   <= CNT_W'(1);
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (valid_in) begin
            frame_err <= 1'b1;
            sh        <= shifted[WIDTH-2:0];
            cnt       <= CNT_W'(1);
          end else if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            sh  <= shifted[WIDTH-2:0];
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  s2p_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (word_done),
    .word     (shifted),
    .ready_in (ready_in),
    .dout     (dout),
    .valid_out(valid_out),
    .ovf      (ovf)
  );

`ifdef SERIAL2PARALLEL_ERR_CNT_EN
  // Count every error pulse, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if ((frame_err || ovf) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/serial2parallel.md
# serial2parallel

Deserializer stage that consumes the 1-bit stream and word-start pulse produced by the team's parallel-to-serial serializer and rebuilds WIDTH-bit parallel words. Frames are MSB first, with the start strobe coincident with the MSB. Reassembled words are presented on a valid/ready output port through a one-entry holding register. Framing and overflow faults are flagged, never silently merged.

## Interface
- WIDTH, 4: word width in bits; must be at least 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit, MSB of a word first.
- valid_in  input  1  word-start strobe; high in the cycle din carries the MSB.
- dout  output  WIDTH  reassembled word; stable while valid_out is high.
- valid_out  output  1  holding register contains a word.
- ready_in  input  1  downstream accepts dout on a cycle where valid_out && ready_in.
- frame_err  output  1  one-cycle pulse: a frame was aborted by an early valid_in.
- ovf  output  1  one-cycle pulse: a complete word was dropped because the holding register was full.

## Operation
- Two-state FSM: IDLE and SHIFT.
- IDLE
  - din is ignored while valid_in is low, including the zero bits the serializer emits after reset.
  - valid_in=1: sh <= {.., din}, cnt <= 1, go to SHIFT.
- SHIFT
  - valid_in=0: sh <= {sh[WIDTH-2:0], din}, cnt <= cnt+1.
  - valid_in=1 at any cnt (1..WIDTH-1): frame_err pulses and the partial word is discarded. The current bit is taken as the MSB of a new frame (cnt <= 1, remain in SHIFT).
- Completion: a word is complete in SHIFT when cnt==WIDTH-1 and valid_in=0. The assembled word is {sh[WIDTH-2:0], din}, and the FSM returns to IDLE.
- Holding register
  - Accepts a completed word if it is empty, or if it is being drained in the same cycle (valid_out && ready_in).
  - Otherwise the new word is dropped, ovf pulses, and the held word is kept unchanged.
  - The register is cleared when drained with no simultaneous load.
- cnt width is $clog2(WIDTH). cnt never wraps past WIDTH-1.

## Timing
- Reset values: dout=0, valid_out=0, frame_err=0, ovf=0, state=IDLE, cnt=0, sh=0.
- Reset is asynchronous. Assertion mid-frame drops the partial word and any held word immediately.
- Latency: valid_in high in cycle k (with the MSB) gives valid_out high in cycle k+WIDTH, provided the register was empty or draining.
- Back-to-back frames (valid_in every WIDTH cycles) are sustained at full rate when ready_in is held high.
- frame_err and ovf are registered. They are high in the cycle after the offending edge.
- A frame_err and an ovf cannot occur in the same cycle.
- valid_out/dout obey valid/ready: once valid_out is high, dout does not change until the handshake completes.

## Configuration
- SERIAL2PARALLEL_ERR_CNT_EN defined:
  - Adds output err_cnt [7:0], reset 0.
  - Increments on each frame_err or ovf pulse.
  - Saturates at 8'hFF and does not wrap.
- Not defined: the err_cnt port and its logic are absent. All other behaviour is identical.

## Structure
- Package s2p_pkg:
  - state enum (S_IDLE, S_SHIFT).
  - Default WIDTH constant.
  - ERR_CNT_W = 8.
- One sub-module, s2p_hold_reg: the one-entry valid/ready holding register, with load/accept/ovf logic. The FSM and shifter stay in the top.

## Test plan
- Reset, then din=0 and valid_in=0 for 6 cycles: valid_out stays 0 and no error pulse occurs.
- Single frame of 4'b1011 (valid_in with din=1, then 0,1,1), ready_in=1: dout=4'hB with valid_out high exactly 4 cycles after the strobe, for 1 cycle.
- Continuous frames A, 5, F, 0 with ready_in=1: four consecutive valid words at a 4-cycle spacing, in order, with no ovf.
- Second valid_in 2 cycles into a frame, then bits complete for 4'h6: frame_err pulses once and only 4'h6 is output.
- ready_in=0 while frames 3 and then C complete: dout holds 3, ovf pulses once for C. Raising ready_in drains 3 and valid_out then drops.
- With SERIAL2PARALLEL_ERR_CNT_EN: 300 forced framing errors give err_cnt = 8'hFF. Asserting rst mid-frame clears err_cnt, valid_out and the FSM.
